// File: rtl/tt_sar_pkg.sv
// Shared definitions for the SAR ADC controller.
//   state_t      : controller FSM states
//   UIO_*        : bit positions of the status flags on uio_out
//   UIO_OE_MASK  : fixed output-enable pattern for the bidirectional pins
package tt_sar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_TRIAL  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int UIO_SAMPLE = 0;
  localparam int UIO_BUSY   = 1;
  localparam int UIO_EOC    = 2;

  localparam logic [7:0] UIO_OE_MASK = 8'b0000_0111;

endpackage

// File: rtl/tt_um_anweiteck_sar_ctrl_if.sv
// Bundle of the controller's digital pin groups.
//   master : drives ui_in / uio_in, observes uo_out / uio_out / uio_oe
//   slave  : the controller side of the same pins
interface sar_io_if;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ui_in, output uio_in,
                  input uo_out, input uio_out, input uio_oe);
  modport slave  (input ui_in, input uio_in,
                  output uo_out, output uio_out, output uio_oe);
endinterface

// File: rtl/sar_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
//   clk, rst_n : clock, synchronous active-low reset (clears both flops)
//   d          : asynchronous input
//   q          : synchronized output, two cycles of latency
module sar_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/tt_um_anweiteck_sar_ctrl.sv
// Successive-approximation ADC controller (Tiny Tapeout wrapper).
//   ui_in[0] cmp (Vin >= Vdac), ui_in[1] start, ui_in[2] cont
//   uo_out   trial DAC code while busy, held result otherwise
//   uio_out  [0] sample, [1] busy, [2] eoc; uio_oe constant
//   ena, uio_in, ua, VGND, VDPWR carry no logic
// Optional macro SAR_AVG_EN: four back-to-back conversions per start,
// result is the truncated mean of the four codes.
module tt_um_anweiteck_sar_ctrl
  import tt_sar_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic [7:0] uio_in,
  inout  wire  [7:0] ua,
  input  wire        VGND,
  input  wire        VDPWR
);

  state_t     state, state_n;
  logic       cmp_s, start_s, start_d, start_ev;
  logic [7:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] trial, trial_n, decided, result;
  logic       samp_last, bit_last, conv_last, enter_sample;
`ifdef SAR_AVG_EN
  logic [1:0] conv_cnt;
  logic [9:0] acc, acc_n;
`endif

  sar_sync2 u_sync_cmp   (.clk(clk), .rst_n(rst_n), .d(ui_in[0]), .q(cmp_s));
  sar_sync2 u_sync_start (.clk(clk), .rst_n(rst_n), .d(ui_in[1]), .q(start_s));

  assign start_ev     = start_s & ~start_d;
  assign samp_last    = (state == ST_SAMPLE) && (cnt == 8'(SAMPLE_CYCLES - 1));
  assign bit_last     = (state == ST_TRIAL)  && (cnt == 8'(SETTLE_CYCLES));
  assign conv_last    = bit_last && (bit_idx == 3'd0);
  assign enter_sample = (state_n == ST_SAMPLE) && (state != ST_SAMPLE);

  // Decide the current bit, then raise the next lower one as the new trial.
  always_comb begin
    decided          = trial;
    decided[bit_idx] = cmp_s;
    trial_n          = decided;
    if (bit_idx != 3'd0) trial_n[bit_idx - 3'd1] = 1'b1;
  end

`ifdef SAR_AVG_EN
  assign acc_n = acc + {2'b00, decided};
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:   if (start_ev)  state_n = ST_SAMPLE;
      ST_SAMPLE: if (samp_last) state_n = ST_TRIAL;
`ifdef SAR_AVG_EN
      ST_TRIAL:  if (conv_last) state_n = (conv_cnt == 2'd3) ? ST_DONE : ST_SAMPLE;
`else
      ST_TRIAL:  if (conv_last) state_n = ST_DONE;
`endif
      ST_DONE:   state_n = ui_in[2] ? ST_SAMPLE : ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    uio_out             = 8'h00;
    uio_out[UIO_SAMPLE] = (state == ST_SAMPLE);
    uio_out[UIO_BUSY]   = (state == ST_SAMPLE) || (state == ST_TRIAL);
    uio_out[UIO_EOC]    = (state == ST_DONE);
    uo_out              = uio_out[UIO_BUSY] ? trial : result;
  end

  assign uio_oe = UIO_OE_MASK;

  // Datapath: counters, trial code, result. The result is written on the
  // edge that enters DONE so it is already visible during the eoc cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_d  <= 1'b0;
      cnt      <= 8'h00;
      bit_idx  <= 3'd0;
      trial    <= 8'h00;
      result   <= 8'h00;
`ifdef SAR_AVG_EN
      conv_cnt <= 2'd0;
      acc      <= 10'd0;
`endif
    end else begin
      start_d <= start_s;
      unique case (state)
        ST_SAMPLE: begin
          if (samp_last) begin
            cnt     <= 8'h00;
            bit_idx <= 3'd7;
          end else cnt <= cnt + 8'h01;
        end
        ST_TRIAL: begin
          if (bit_last) begin
            cnt     <= 8'h00;
            trial   <= trial_n;
            bit_idx <= bit_idx - 3'd1;
          end else cnt <= cnt + 8'h01;
          if (conv_last) begin
`ifdef SAR_AVG_EN
            if (conv_cnt == 2'd3) begin
              result   <= acc_n[9:2];
              acc      <= 10'd0;
              conv_cnt <= 2'd0;
            end else begin
              acc      <= acc_n;
              conv_cnt <= conv_cnt + 2'd1;
            end
`else
            result <= decided;
`endif
          end
        end
        default: ;
      endcase
      if (enter_sample) begin
        cnt   <= 8'h00;
        trial <= 8'h80;
      end
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:3], uio_in, ua, VGND, VDPWR};

endmodule

// File: tb/tb_tt_um_anweiteck_sar_ctrl.sv
// Self-checking bench for tt_um_anweiteck_sar_ctrl. The comparator is modelled
// as cmp = (vin >= uo_out). Honours SAR_AVG_EN when defined.
module tb_tt_um_anweiteck_sar_ctrl;

`ifdef SAR_AVG_EN
  localparam int CONV_LEN = 4 * 36 + 1;
`else
  localparam int CONV_LEN = 37;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic [7:0] vin = 8'h00;
  logic       cmp_m;
  wire  [7:0] ua;

  sar_io_if io();

  assign cmp_m     = (vin >= io.uo_out);
  assign io.ui_in  = {5'b00000, cont, start, cmp_m};
  assign io.uio_in = 8'h00;

  tt_um_anweiteck_sar_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .ui_in(io.ui_in), .uo_out(io.uo_out),
    .uio_out(io.uio_out), .uio_oe(io.uio_oe), .uio_in(io.uio_in),
    .ua(ua), .VGND(1'b0), .VDPWR(1'b1)
  );

  always #5 clk = ~clk;

  wire smp = io.uio_out[0];
  wire bsy = io.uio_out[1];
  wire eoc = io.uio_out[2];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] vin;
    logic [7:0] exp;
    bit         mid_start;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_sample(output int ok);
    int t = 0;
    while (!smp && t < 20) begin step(); t++; end
    ok = (t < 20) ? 1 : 0;
  endtask

  task automatic quiet(input string nm, input int cycles);
    int extra = 0;
    for (int i = 0; i < cycles; i++) begin
      if (smp || eoc) extra++;
      step();
    end
    chk(nm, extra, 0);
  endtask

  task automatic conv(input logic [7:0] v, input logic [7:0] exp, input bit mid);
    int ok, len;
    vin = v;
    start = 1'b1;
    wait_sample(ok);
    chk("start_to_sample", ok, 1);
    start = 1'b0;
    len = 1;
    while (!eoc && len < 400) begin
      step();
      len++;
      if (mid && len == 10) start = 1'b1;
      if (mid && len == 14) start = 1'b0;
    end
    chk("conv_len", len, CONV_LEN);
    chk("busy_at_eoc", int'(bsy), 0);
    chk("result_at_eoc", int'(io.uo_out), int'(exp));
    step();
    chk("eoc_single_cycle", int'(eoc), 0);
    chk("result_held", int'(io.uo_out), int'(exp));
    if (mid) quiet("mid_start_ignored", 60);
  endtask

`ifdef SAR_AVG_EN
  logic [7:0] avg_vals[4];
`endif

  initial begin
    int ok, len, c, ne;
    int e[3];

    tbl[0] = '{8'hA5, 8'hA5, 1'b0};
    tbl[1] = '{8'h00, 8'h00, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b0};
    tbl[3] = '{8'h3C, 8'h3C, 1'b0};
    tbl[4] = '{8'h55, 8'h55, 1'b1};
    tbl[5] = '{8'h01, 8'h01, 1'b0};
    tbl[6] = '{8'h80, 8'h80, 1'b0};
    tbl[7] = '{8'h7F, 8'h7F, 1'b0};

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk("reset_uo_out", int'(io.uo_out), 8'h00);
    chk("reset_uio_out", int'(io.uio_out), 8'h00);
    chk("reset_uio_oe", int'(io.uio_oe), 8'h07);
    rst_n = 1'b1;
    step();
    quiet("idle_without_start", 10);

    for (int i = 0; i < 8; i++) conv(tbl[i].vin, tbl[i].exp, tbl[i].mid_start);

    // Continuous mode, cont dropped during the third conversion
    vin = 8'h3C;
    cont = 1'b1;
    start = 1'b1;
    wait_sample(ok);
    chk("cont_start", ok, 1);
    start = 1'b0;
    c = 0;
    ne = 0;
    while (ne < 3 && c < 2000) begin
      if (eoc) begin
        e[ne] = c;
        chk("cont_result", int'(io.uo_out), 8'h3C);
        ne++;
      end
      if (ne == 2 && c == e[1] + 10) cont = 1'b0;
      step();
      c++;
    end
    chk("cont_eoc_count", ne, 3);
    if (ne == 3) begin
      chk("cont_first_len", e[0] + 1, CONV_LEN);
      chk("cont_interval1", e[1] - e[0], CONV_LEN);
      chk("cont_interval2", e[2] - e[1], CONV_LEN);
    end
    cont = 1'b0;
    quiet("cont_back_to_idle", 60);

    // Reset in the middle of bit 4
    vin = 8'h5A;
    start = 1'b1;
    wait_sample(ok);
    chk("rst_test_start", ok, 1);
    start = 1'b0;
    len = 1;
    while (len < 18) begin step(); len++; end
    chk("trial_bit4", int'(io.uo_out), 8'h50);
    chk("busy_bit4", int'(bsy), 1);
    rst_n = 1'b0;
    step();
    chk("midrst_uo_out", int'(io.uo_out), 8'h00);
    chk("midrst_uio_out", int'(io.uio_out), 8'h00);
    chk("midrst_uio_oe", int'(io.uio_oe), 8'h07);
    rst_n = 1'b1;
    quiet("midrst_no_eoc", 60);
    conv(8'h5A, 8'h5A, 1'b0);

`ifdef SAR_AVG_EN
    // Averaging with a different input per conversion: (0x10+0x14+0x10+0x15)/4 -> 0x12
    avg_vals[0] = 8'h10; avg_vals[1] = 8'h14; avg_vals[2] = 8'h10; avg_vals[3] = 8'h15;
    begin
      int k, neoc;
      logic prev;
      vin = avg_vals[0];
      k = 1;
      start = 1'b1;
      wait_sample(ok);
      chk("avg_start", ok, 1);
      start = 1'b0;
      prev = 1'b1;
      len = 1;
      neoc = 0;
      while (!eoc && len < 400) begin
        step();
        len++;
        if (smp && !prev && k < 4) begin vin = avg_vals[k]; k++; end
        if (!bsy && !eoc) neoc++;
        prev = smp;
      end
      chk("avg_len", len, 145);
      chk("avg_result", int'(io.uo_out), 8'h12);
      chk("avg_busy_gaps", neoc, 0);
      step();
      quiet("avg_single_eoc", 40);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
